mha_stage_sequencer: RTL and testbench
======================================

# mha_stage_sequencer

Multi-head attention stage sequencer: runs the attention pipeline (QKV → score → softmax → precision assign → A·V) once per head for a run-time-selected head count, then the shared W_O projection once. It drives one-cycle start pulses to the external stage engines and waits on their done strobes. It adds per-stage watchdog timeout, abort, a precision-assign bypass mode, and run-cycle accounting. It replaces the fixed single-head start/done chaining in the attention top level; the datapaths stay in the existing engines.

## Interface
- MAX_HEADS, default 4: maximum heads per run (≥1)
- TIMEOUT_CYCLES, default 4096: WAIT-cycle limit per stage; 0 disables the watchdog
- HW = max(1, $clog2(MAX_HEADS)), derived: head index width
- CW = $clog2(MAX_HEADS+1), derived: head-count config width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- start  in  1  begin run; accepted only in IDLE or ERR
- num_heads_cfg  in  CW  heads to run; sampled at accepted start
- bypass_prec  in  1  skip PRECISION stage; sampled at accepted start
- abort  in  1  cancel current run
- stg_done  in  6  per-stage done strobes: [0]QKV [1]SCORE [2]SOFTMAX [3]PREC [4]AV [5]WO
- stg_start  out  6  one-hot start pulse to the current stage engine
- head_idx  out  HW  head being processed
- prec_bypass  out  1  registered bypass_prec for the AV engine (all-FP16 when 1)
- busy  out  1  run in progress
- done  out  1  one-cycle run-complete pulse
- err  out  1  watchdog fired; held until next accepted start
- err_stage  out  3  stage code that timed out
- cycle_count  out  32  cycles used by the last run

## Operation
- States: IDLE, LAUNCH, WAIT, DONE, ERR.
- Accepted start (IDLE/ERR, start=1) does the following:
  - latch H = clamp(num_heads_cfg, 1, MAX_HEADS); 0 → 1, >MAX_HEADS → MAX_HEADS
  - latch prec_bypass
  - head_idx←0, stage←QKV, err←0, err_stage←0, cycle_count←0
  - go to LAUNCH
- LAUNCH: stg_start[stage]=1 for exactly this cycle. Clear the watchdog counter. Go to WAIT.
- WAIT: only stg_done[stage] is sampled. Other bits, and any done seen during LAUNCH, are ignored.
  - On done, choose the next stage:
    - QKV→SCORE→SOFTMAX→PREC→AV; with bypass, SOFTMAX→AV.
    - After AV, if head_idx<H-1: head_idx+1, stage←QKV.
    - Otherwise stage←WO.
    - After WO, go to DONE instead of LAUNCH.
  - If not done: increment the watchdog. When TIMEOUT_CYCLES≠0 and this is the TIMEOUT_CYCLES-th WAIT cycle with done still low, go to ERR and set err_stage←stage. A done on that cycle counts as success.
- DONE: done=1 for one cycle, then IDLE.
- ERR: err=1, busy=0. Wait for start.
- abort in LAUNCH/WAIT/DONE: next state IDLE. No done, err unchanged, stg_start low in the following cycle. abort in IDLE/ERR is ignored. abort beats done and timeout in the same cycle.
- start while busy: ignored.
- busy=1 in LAUNCH, WAIT, DONE.
- cycle_count increments every cycle in LAUNCH/WAIT/DONE. It holds otherwise, including after abort and ERR.
- head_idx holds H-1 during WO and after completion.

## Timing
- Reset value of all outputs is 0: stg_start, head_idx, prec_bypass, busy, done, err, err_stage, cycle_count. Reset asserted mid-run forces IDLE immediately.
- All outputs are registered or decoded from registered state. No combinational path from inputs to outputs.
- Start sampled in cycle 0 → first stg_start in cycle 1.
- Per-stage overhead: LAUNCH cycle plus the done cycle. A stage whose done arrives on its first WAIT cycle costs 2 cycles.
- With P = 5 (4 if bypass) and N = H·P+1 stages, zero-wait engines give:
  - last WAIT in cycle 2N
  - done pulse in cycle 2N+1
  - cycle_count = 2N+1
  - busy low from cycle 2N+2
- Next start is accepted in the first IDLE cycle.

## Test plan
- H=1, no bypass, engines assert done on first WAIT cycle → pulses QKV,SCORE,SOFTMAX,PREC,AV,WO in cycles 1,3,5,7,9,11; done in cycle 13; cycle_count=13.
- num_heads_cfg=2, bypass_prec=1, zero-wait → PREC never pulsed, head_idx 0→1 after first AV, done in cycle 19, cycle_count=19, prec_bypass=1.
- num_heads_cfg=0 then 7 (MAX_HEADS=4) → 1 and 4 heads run respectively; AV pulsed 1 and 4 times; WO pulsed once each.
- TIMEOUT_CYCLES=16, SOFTMAX done withheld on head 0 → WAIT cycles 6–21, ERR in cycle 22, err=1, err_stage=2, busy=0, no done. New start clears err. Done on cycle 21 instead → no error.
- abort during AV WAIT of head 1 (H=2) coincident with stg_done[4] → IDLE next cycle, no WO pulse, no done; stray stg_done on non-current bits throughout run ignored.
- rst_n low mid-WAIT → all outputs 0 asynchronously. start after release runs cleanly from QKV, head 0.

Source files
------------

// File: rtl/mha_stage_sequencer.sv
// Multi-head attention stage sequencer: launches QKV/SCORE/SOFTMAX/PREC/AV once per head,
// then the shared W_O projection, with per-stage watchdog, abort and run-cycle accounting.
module mha_stage_sequencer #(
  parameter  int MAX_HEADS      = 4,
  parameter  int TIMEOUT_CYCLES = 4096,
  localparam int HW             = (MAX_HEADS > 1) ? $clog2(MAX_HEADS) : 1,
  localparam int CW             = $clog2(MAX_HEADS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] num_heads_cfg,
  input  logic          bypass_prec,
  input  logic          abort,
  input  logic [5:0]    stg_done,
  output logic [5:0]    stg_start,
  output logic [HW-1:0] head_idx,
  output logic          prec_bypass,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [2:0]    err_stage,
  output logic [31:0]   cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  // Stage codes double as the bit index into stg_start/stg_done and as err_stage.
  typedef enum logic [2:0] {
    STG_QKV     = 3'd0,
    STG_SCORE   = 3'd1,
    STG_SOFTMAX = 3'd2,
    STG_PREC    = 3'd3,
    STG_AV      = 3'd4,
    STG_WO      = 3'd5
  } stage_t;

  localparam logic [31:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  state_t        r_state;
  state_t        w_next_state;
  stage_t        r_stage;
  stage_t        w_next_stage;
  logic [CW-1:0] r_num_heads;
  logic [HW-1:0] r_head_idx;
  logic          r_prec_bypass;
  logic          r_err;
  logic [2:0]    r_err_stage;
  logic [31:0]   r_cycle_count;
  logic [31:0]   r_wdog;

  logic          w_accept;
  logic          w_cur_done;
  logic          w_timeout;
  logic          w_more_heads;
  logic [CW-1:0] w_heads_clamped;
  logic [5:0]    w_stg_start;
  logic          w_busy;
  logic          w_done;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_accept     = start && (r_state == S_IDLE || r_state == S_ERR);
    w_cur_done   = stg_done[r_stage];
    w_timeout    = (TIMEOUT_CYCLES != 0) && (r_wdog == TO_LAST) && !w_cur_done;
    w_more_heads = (CW'(r_head_idx) + CW'(1)) < r_num_heads;

    w_heads_clamped = num_heads_cfg;
    if (num_heads_cfg == '0)                  w_heads_clamped = CW'(1);
    else if (num_heads_cfg > CW'(MAX_HEADS))  w_heads_clamped = CW'(MAX_HEADS);

    w_next_stage = r_stage;
    case (r_stage)
      STG_QKV:     w_next_stage = STG_SCORE;
      STG_SCORE:   w_next_stage = STG_SOFTMAX;
      STG_SOFTMAX: w_next_stage = r_prec_bypass ? STG_AV : STG_PREC;
      STG_PREC:    w_next_stage = STG_AV;
      STG_AV:      w_next_stage = w_more_heads ? STG_QKV : STG_WO;
      default:     w_next_stage = r_stage;
    endcase

    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_ERR: if (w_accept) w_next_state = S_LAUNCH;
      S_LAUNCH:      w_next_state = abort ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (abort)           w_next_state = S_IDLE;
        else if (w_cur_done) w_next_state = (r_stage == STG_WO) ? S_DONE : S_LAUNCH;
        else if (w_timeout)  w_next_state = S_ERR;
      end
      S_DONE:        w_next_state = S_IDLE;
      default:       w_next_state = S_IDLE;
    endcase
  end

  // Output decode.
  // NOTE: outputs depend only on registered state, never directly on inputs.
  always_comb begin
    w_stg_start = '0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_LAUNCH: begin
        w_stg_start = 6'b1 << r_stage;
        w_busy      = 1'b1;
      end
      S_WAIT:  w_busy = 1'b1;
      S_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Run context, watchdog and accounting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num_heads   <= CW'(1);
      r_head_idx    <= '0;
      r_stage       <= STG_QKV;
      r_prec_bypass <= 1'b0;
      r_err         <= 1'b0;
      r_err_stage   <= '0;
      r_cycle_count <= '0;
      r_wdog        <= '0;
    end else if (w_accept) begin
      r_num_heads   <= w_heads_clamped;
      r_head_idx    <= '0;
      r_stage       <= STG_QKV;
      r_prec_bypass <= bypass_prec;
      r_err         <= 1'b0;
      r_err_stage   <= '0;
      r_cycle_count <= '0;
      r_wdog        <= '0;
    end else begin
      if (w_busy) r_cycle_count <= r_cycle_count + 32'd1;
      if (r_state == S_LAUNCH) r_wdog <= '0;
      if (r_state == S_WAIT && !abort) begin
        if (w_cur_done) begin
          r_stage <= w_next_stage;
          if (r_stage == STG_AV && w_more_heads) r_head_idx <= r_head_idx + HW'(1);
        end else begin
          r_wdog <= r_wdog + 32'd1;
          if (w_timeout) begin
            r_err       <= 1'b1;
            r_err_stage <= r_stage;
          end
        end
      end
    end
  end

  assign stg_start   = w_stg_start;
  assign busy        = w_busy;
  assign done        = w_done;
  assign head_idx    = r_head_idx;
  assign prec_bypass = r_prec_bypass;
  assign err         = r_err;
  assign err_stage   = r_err_stage;
  assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_mha_stage_sequencer.sv
// Directed bench for mha_stage_sequencer: a table of whole-run vectors against a simple
// engine model, plus hand sequences for pulse timing, head stepping and mid-run reset.
module tb_mha_stage_sequencer;

  localparam int MAXH = 4;
  localparam int TO   = 16;
  localparam int HW   = 2;
  localparam int CW   = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_heads_cfg = '0;
  logic          bypass_prec = 1'b0;
  logic          abort = 1'b0;
  logic [5:0]    stg_done = '0;
  logic [5:0]    stg_start;
  logic [HW-1:0] head_idx;
  logic          prec_bypass;
  logic          busy;
  logic          done;
  logic          err;
  logic [2:0]    err_stage;
  logic [31:0]   cycle_count;

  mha_stage_sequencer #(.MAX_HEADS(MAXH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_heads_cfg(num_heads_cfg),
    .bypass_prec(bypass_prec), .abort(abort), .stg_done(stg_done),
    .stg_start(stg_start), .head_idx(head_idx), .prec_bypass(prec_bypass),
    .busy(busy), .done(done), .err(err), .err_stage(err_stage), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  // Engine-model knobs and per-run observations.
  int g_hold_stage, g_hold_head, g_hold_wait, g_abort_cyc;
  bit g_stray;
  int r_done_cyc, r_end_cyc, r_ndone, r_last_qkv_cyc, r_last_qkv_head;
  int r_cnt[6];
  int r_first[6];
  logic [5:0] r_end_stg;

  task automatic set_knobs(input int hs, input int hh, input int hw, input int ab, input bit stray);
    g_hold_stage = hs; g_hold_head = hh; g_hold_wait = hw; g_abort_cyc = ab; g_stray = stray;
  endtask

  // Called at a negedge in an idle cycle; that cycle is cycle 0 of the run.
  task automatic do_run(input logic [CW-1:0] cfg, input logic byp);
    int pend, pend_head, wcnt, hold;
    pend = -1; pend_head = 0; wcnt = 0;
    r_done_cyc = -1; r_end_cyc = -1; r_ndone = 0; r_last_qkv_cyc = -1; r_last_qkv_head = -1;
    r_end_stg = '0;
    for (int s = 0; s < 6; s++) begin r_cnt[s] = 0; r_first[s] = -1; end
    num_heads_cfg = cfg; bypass_prec = byp; start = 1'b1; abort = 1'b0; stg_done = '0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      start    = g_stray;
      abort    = (c == g_abort_cyc);
      stg_done = '0;
      if (done) begin r_ndone++; r_done_cyc = c; end
      if (!busy) begin
        r_end_cyc = c; r_end_stg = stg_start;
        start = 1'b0; abort = 1'b0;
        break;
      end
      if (stg_start != '0) begin
        for (int s = 0; s < 6; s++) begin
          if (stg_start[s]) begin
            r_cnt[s]++;
            if (r_first[s] < 0) r_first[s] = c;
            if (s == 0) begin r_last_qkv_cyc = c; r_last_qkv_head = int'(head_idx); end
            pend = s;
          end
        end
        pend_head = int'(head_idx); wcnt = 0;
        if (g_stray) stg_done = 6'h3F;
      end else if (pend >= 0) begin
        wcnt++;
        hold = (pend == g_hold_stage && pend_head == g_hold_head) ? g_hold_wait : 0;
        if (wcnt > hold) begin
          stg_done = g_stray ? 6'h3F : 6'(1 << pend);
          pend = -1;
        end else if (g_stray) begin
          stg_done = 6'h3F & ~6'(1 << pend);
        end
      end
    end
    if (r_end_cyc < 0) check("run_bounded", 0, 1);
  endtask

  typedef struct {
    logic [CW-1:0] cfg;
    logic          byp;
    int            hs, hh, hw, ab;
    bit            stray;
    int            e_done, e_end, e_cnt;
    logic          e_err;
    logic [2:0]    e_es;
    int            e_av, e_prec, e_wo;
    logic [HW-1:0] e_head;
  } vec_t;

  vec_t vt[9];

  initial begin
    // cfg byp  hs hh hw  ab  stray done end cnt err es av prec wo head
    vt[0] = '{3'd1, 1'b0, -1, 0,  0, -1, 1'b0, 13, 14, 13, 1'b0, 3'd0, 1, 1, 1, 2'd0};
    vt[1] = '{3'd2, 1'b1, -1, 0,  0, -1, 1'b0, 19, 20, 19, 1'b0, 3'd0, 2, 0, 1, 2'd1};
    vt[2] = '{3'd0, 1'b0, -1, 0,  0, -1, 1'b0, 13, 14, 13, 1'b0, 3'd0, 1, 1, 1, 2'd0};
    vt[3] = '{3'd7, 1'b0, -1, 0,  0, -1, 1'b0, 43, 44, 43, 1'b0, 3'd0, 4, 4, 1, 2'd3};
    vt[4] = '{3'd1, 1'b0,  2, 0, 16, -1, 1'b0, -1, 22, 21, 1'b1, 3'd2, 0, 0, 0, 2'd0};
    vt[5] = '{3'd1, 1'b0,  2, 0, 15, -1, 1'b0, 28, 29, 28, 1'b0, 3'd0, 1, 1, 1, 2'd0};
    vt[6] = '{3'd2, 1'b0,  1, 1,  3, 23, 1'b1, -1, 24, 23, 1'b0, 3'd0, 2, 2, 0, 2'd1};
    vt[7] = '{3'd3, 1'b1,  5, 2, 16, -1, 1'b0, -1, 42, 41, 1'b1, 3'd5, 3, 0, 1, 2'd2};
    vt[8] = '{3'd1, 1'b0, -1, 0,  0,  1, 1'b0, -1,  2,  1, 1'b0, 3'd0, 0, 0, 0, 2'd0};

    #1;
    check("rst_stg_start", stg_start, 0);
    check("rst_busy_done", {busy, done}, 0);
    check("rst_err", {err, err_stage}, 0);
    check("rst_misc", {head_idx, prec_bypass, cycle_count}, 0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      set_knobs(vt[i].hs, vt[i].hh, vt[i].hw, vt[i].ab, vt[i].stray);
      do_run(vt[i].cfg, vt[i].byp);
      check($sformatf("v%0d_done_cyc", i), r_done_cyc, vt[i].e_done);
      check($sformatf("v%0d_ndone", i), r_ndone, (vt[i].e_done < 0) ? 0 : 1);
      check($sformatf("v%0d_end_cyc", i), r_end_cyc, vt[i].e_end);
      check($sformatf("v%0d_cycle_count", i), cycle_count, vt[i].e_cnt);
      check($sformatf("v%0d_err", i), err, vt[i].e_err);
      check($sformatf("v%0d_err_stage", i), err_stage, vt[i].e_es);
      check($sformatf("v%0d_av", i), r_cnt[4], vt[i].e_av);
      check($sformatf("v%0d_prec", i), r_cnt[3], vt[i].e_prec);
      check($sformatf("v%0d_wo", i), r_cnt[5], vt[i].e_wo);
      check($sformatf("v%0d_head", i), head_idx, vt[i].e_head);
      check($sformatf("v%0d_bypass", i), prec_bypass, vt[i].byp);
      check($sformatf("v%0d_idle_out", i), {r_end_stg, done}, 0);
    end

    // Exact pulse cycles for a single zero-wait head.
    set_knobs(-1, 0, 0, -1, 1'b0);
    do_run(3'd1, 1'b0);
    for (int s = 0; s < 6; s++) check($sformatf("h1_first_%0d", s), r_first[s], 1 + 2 * s);

    // Two heads with bypass: head 1 QKV launched right after head 0 AV.
    do_run(3'd2, 1'b1);
    check("byp_av0_cyc", r_first[4], 7);
    check("byp_qkv1_cyc", r_last_qkv_cyc, 9);
    check("byp_qkv1_head", r_last_qkv_head, 1);
    check("byp_wo_cyc", r_first[5], 17);

    // Asynchronous reset in the middle of a WAIT.
    num_heads_cfg = 3'd2; bypass_prec = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", busy, 1);
    check("pre_rst_count", cycle_count, 1);
    check("pre_rst_bypass", prec_bypass, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_outputs",
          {stg_start, head_idx, prec_bypass, busy, done, err, err_stage, cycle_count}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_run(3'd1, 1'b0);
    check("post_rst_qkv_cyc", r_first[0], 1);
    check("post_rst_qkv_head", r_last_qkv_head, 0);
    check("post_rst_done_cyc", r_done_cyc, 13);
    check("post_rst_count", cycle_count, 13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
